// File: rtl/bus_sched_pkg.sv
// Shared phase constants, slot encoding and helpers for the bus time-division scheduler.
package bus_sched_pkg;

  localparam int unsigned PHASE_W = 4;

  typedef logic [PHASE_W-1:0] phase_t;

  // Slot boundaries within the 16-phase CPU cycle
  localparam phase_t PH_VID0     = 4'd0;
  localparam phase_t PH_VID1     = 4'd2;
  localparam phase_t PH_VID_LAST = 4'd3;
  localparam phase_t PH_SPI      = 4'd4;
  localparam phase_t PH_BE       = 4'd7;
  localparam phase_t PH_CPU      = 4'd8;

  // SPI strobe and pulse phases
  localparam phase_t SPI_STB_FIRST = 4'd5;
  localparam phase_t SPI_STB_LAST  = 4'd6;
  localparam phase_t SPI_LOAD      = 4'd6;
  localparam phase_t SPI_ACK       = 4'd7;

  // CPU strobe phases
  localparam phase_t CPU_RW_SAMPLE = 4'd9;
  localparam phase_t CPU_OE_FIRST  = 4'd9;
  localparam phase_t CPU_OE_LAST   = 4'd15;
  localparam phase_t CPU_WE_FIRST  = 4'd11;
  localparam phase_t CPU_WE_LAST   = 4'd14;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_VIDEO,
    SLOT_SPI,
    SLOT_CPU
  } slot_t;

  // Inclusive phase range test
  function automatic logic phase_in(phase_t p, phase_t lo, phase_t hi);
    return (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Free-running 4-bit phase counter that wraps 15 -> 0 every CPU cycle.
module phase_counter
  import bus_sched_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  output phase_t phase
);

  // Advance one phase per fabric clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else begin
      phase <= phase + PHASE_W'(1);
    end
  end

endmodule

// File: rtl/bus_scheduler.sv
// Time-division bus/RAM scheduler: video, SPI bridge and 6502 slots within each 1 us frame.
// Every output is registered from the phase about to be entered, so it is valid for that whole phase.
module bus_scheduler
  import bus_sched_pkg::*;
#(
  parameter bit VIDEO_EN = 1'b1
) (
  input  logic clk16_i,
  input  logic reset_i,
  input  logic spi_req_i,
  input  logic spi_we_i,
  output logic spi_ack_o,
  input  logic cpu_rw_ni,
  input  logic cpu_ready_i,
  output logic grant_video_o,
  output logic grant_spi_o,
  output logic grant_cpu_o,
  output logic video_load_o,
  output logic spi_load_o,
  output logic cpu_clk_o,
  output logic cpu_be_o,
  output logic cpu_ready_o,
  output logic ram_oe_no,
  output logic ram_we_no
);

  phase_t phase;
  phase_t phase_nxt;
  logic   spi_act;
  logic   spi_we_q;
  logic   cpu_rd_q;
  logic   spi_run;
  logic   spi_wr;
  logic   cpu_rd;
  slot_t  slot_nxt;
  logic   oe_c;
  logic   we_c;

  phase_counter u_phase (
    .clk   (clk16_i),
    .rst   (reset_i),
    .phase (phase)
  );

  // Decode owner and RAM strobes for the phase being entered; the entry edge itself samples requests
  always_comb begin
    phase_nxt = phase + PHASE_W'(1);
    spi_run   = (phase_nxt == PH_SPI) ? spi_req_i : spi_act;
    spi_wr    = (phase_nxt == PH_SPI) ? spi_we_i : spi_we_q;
    cpu_rd    = (phase_nxt == CPU_RW_SAMPLE) ? cpu_rw_ni : cpu_rd_q;

    slot_nxt = SLOT_IDLE;
    if (phase_nxt >= PH_CPU) begin
      slot_nxt = SLOT_CPU;
    end else if (phase_nxt >= PH_SPI) begin
      if (spi_run) slot_nxt = SLOT_SPI;
    end else if (VIDEO_EN) begin
      slot_nxt = SLOT_VIDEO;
    end

    oe_c = (slot_nxt == SLOT_VIDEO)
        || ((slot_nxt == SLOT_SPI) && !spi_wr && phase_in(phase_nxt, SPI_STB_FIRST, SPI_STB_LAST))
        || ((slot_nxt == SLOT_CPU) && cpu_rd && phase_in(phase_nxt, CPU_OE_FIRST, CPU_OE_LAST));
    we_c = ((slot_nxt == SLOT_SPI) && spi_wr && phase_in(phase_nxt, SPI_STB_FIRST, SPI_STB_LAST))
        || ((slot_nxt == SLOT_CPU) && !cpu_rd && phase_in(phase_nxt, CPU_WE_FIRST, CPU_WE_LAST));
  end

  // Hold the accepted SPI transaction and CPU direction for the rest of their slots
  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i) begin
      spi_act  <= 1'b0;
      spi_we_q <= 1'b0;
      cpu_rd_q <= 1'b1;
    end else begin
      if (phase_nxt == PH_SPI) begin
        spi_act  <= spi_req_i;
        spi_we_q <= spi_we_i;
      end else if (phase_nxt == PH_CPU) begin
        spi_act <= 1'b0;
      end
      if (phase_nxt == CPU_RW_SAMPLE) cpu_rd_q <= cpu_rw_ni;
    end
  end

  // Register grants, pulses, CPU clocking and RAM strobes
  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i) begin
      grant_video_o <= 1'b0;
      grant_spi_o   <= 1'b0;
      grant_cpu_o   <= 1'b0;
      video_load_o  <= 1'b0;
      spi_load_o    <= 1'b0;
      spi_ack_o     <= 1'b0;
      cpu_clk_o     <= 1'b0;
      cpu_be_o      <= 1'b0;
      cpu_ready_o   <= 1'b0;
      ram_oe_no     <= 1'b1;
      ram_we_no     <= 1'b1;
    end else begin
      grant_video_o <= (slot_nxt == SLOT_VIDEO);
      grant_spi_o   <= (slot_nxt == SLOT_SPI);
      grant_cpu_o   <= (slot_nxt == SLOT_CPU);
      video_load_o  <= (slot_nxt == SLOT_VIDEO)
                    && ((phase_nxt == PH_VID0 + PHASE_W'(1)) || (phase_nxt == PH_VID1 + PHASE_W'(1)));
      spi_load_o    <= (slot_nxt == SLOT_SPI) && !spi_wr && (phase_nxt == SPI_LOAD);
      spi_ack_o     <= (slot_nxt == SLOT_SPI) && (phase_nxt == SPI_ACK);
      cpu_clk_o     <= (slot_nxt == SLOT_CPU);
      cpu_be_o      <= (phase_nxt >= PH_BE);
      // RDY only moves on the edge where PHI2 goes low
      if (phase_nxt == PH_VID0) cpu_ready_o <= cpu_ready_i;
      ram_oe_no     <= !oe_c;
      ram_we_no     <= !we_c;
    end
  end

  // Phases 0-3 are never SPI or CPU owned, so the last video phase bounds the video slot
  logic unused_ok;
  assign unused_ok = phase_in(phase_nxt, PH_VID0, PH_VID_LAST);

endmodule

// File: tb/tb_bus_scheduler.sv
// Self-checking bench for bus_scheduler: directed table, multi-cycle sequences and random traffic
// compared every cycle against a phase-level reference model (VIDEO_EN=1 and VIDEO_EN=0 instances).
module tb_bus_scheduler;

  typedef struct packed {
    logic gv, gs, gc, vload, sload, ack, pclk, be, rdy, oe_n, we_n;
  } outs_t;

  typedef struct {
    bit         req;
    bit         we;
    bit         rw;
    logic [2:0] gnt;   // {video, spi, cpu}
    logic [2:0] pls;   // {video_load, spi_load, spi_ack}
    logic [1:0] cb;    // {cpu_clk, cpu_be}
    logic [1:0] ram;   // {oe_n, we_n}
  } vec_t;

  logic clk       = 1'b0;
  logic reset_i   = 1'b1;
  logic spi_req   = 1'b0;
  logic spi_we    = 1'b0;
  logic cpu_rw    = 1'b1;
  logic cpu_ready = 1'b0;
  wire [10:0] o1;
  wire [10:0] o0;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int ph       = 0;
  bit m_rst    = 1'b1;
  bit m_spi    = 1'b0;
  bit m_spi_we = 1'b0;
  bit m_rd     = 1'b1;
  bit m_rdy    = 1'b0;

  vec_t tbl [32];

  always #5 clk = ~clk;

  bus_scheduler #(.VIDEO_EN(1'b1)) dut (
    .clk16_i(clk), .reset_i(reset_i), .spi_req_i(spi_req), .spi_we_i(spi_we),
    .spi_ack_o(o1[5]), .cpu_rw_ni(cpu_rw), .cpu_ready_i(cpu_ready),
    .grant_video_o(o1[10]), .grant_spi_o(o1[9]), .grant_cpu_o(o1[8]),
    .video_load_o(o1[7]), .spi_load_o(o1[6]), .cpu_clk_o(o1[4]), .cpu_be_o(o1[3]),
    .cpu_ready_o(o1[2]), .ram_oe_no(o1[1]), .ram_we_no(o1[0])
  );

  bus_scheduler #(.VIDEO_EN(1'b0)) dut0 (
    .clk16_i(clk), .reset_i(reset_i), .spi_req_i(spi_req), .spi_we_i(spi_we),
    .spi_ack_o(o0[5]), .cpu_rw_ni(cpu_rw), .cpu_ready_i(cpu_ready),
    .grant_video_o(o0[10]), .grant_spi_o(o0[9]), .grant_cpu_o(o0[8]),
    .video_load_o(o0[7]), .spi_load_o(o0[6]), .cpu_clk_o(o0[4]), .cpu_be_o(o0[3]),
    .cpu_ready_o(o0[2]), .ram_oe_no(o0[1]), .ram_we_no(o0[0])
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(bit req, bit we, bit rw, logic [2:0] gnt, logic [2:0] pls,
                              logic [1:0] cb, logic [1:0] ram);
    vec_t v;
    v.req = req; v.we = we; v.rw = rw; v.gnt = gnt; v.pls = pls; v.cb = cb; v.ram = ram;
    return v;
  endfunction

  function automatic void model_reset();
    ph = 0; m_rst = 1'b1; m_spi = 1'b0; m_spi_we = 1'b0; m_rd = 1'b1; m_rdy = 1'b0;
  endfunction

  // What each output must be in the current phase, from the slot rules
  function automatic outs_t model_out(bit ven);
    outs_t o;
    bit vid_ph;
    bit stb_ph;
    o = '0;
    if (m_rst) begin
      o.oe_n = 1'b1;
      o.we_n = 1'b1;
      return o;
    end
    vid_ph  = (ph < 4);
    stb_ph  = (ph == 5) || (ph == 6);
    o.gv    = ven && vid_ph;
    o.gs    = m_spi && (ph >= 4) && (ph <= 7);
    o.gc    = (ph >= 8);
    o.vload = ven && ((ph == 1) || (ph == 3));
    o.sload = m_spi && !m_spi_we && (ph == 6);
    o.ack   = m_spi && (ph == 7);
    o.pclk  = (ph >= 8);
    o.be    = (ph >= 7);
    o.rdy   = m_rdy;
    o.oe_n  = !((ven && vid_ph) || (m_spi && !m_spi_we && stb_ph) || (m_rd && ph >= 9));
    o.we_n  = !((m_spi && m_spi_we && stb_ph) || (!m_rd && ph >= 11 && ph <= 14));
    return o;
  endfunction

  task automatic check_all();
    chk($sformatf("ven1_ph%0d", ph), 32'(o1), 32'(model_out(1'b1)));
    chk($sformatf("ven0_ph%0d", ph), 32'(o0), 32'(model_out(1'b0)));
  endtask

  // One clock: advance the model on the edge, compare both instances mid-cycle
  task automatic tick();
    @(posedge clk);
    if (reset_i) begin
      model_reset();
    end else begin
      ph    = (ph + 1) % 16;
      m_rst = 1'b0;
      if (ph == 4) begin m_spi = spi_req; m_spi_we = spi_we; end
      if (ph == 9) m_rd = cpu_rw;
      if (ph == 0) m_rdy = cpu_ready;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic go_phase(int target);
    for (int k = 0; k < 16 && ph != target; k++) tick();
  endtask

  // Raise a request in a given phase and measure cycles until ack is seen
  task automatic spi_latency(int start_ph, bit we, int exp_lat);
    int n;
    bit seen;
    spi_req = 1'b0;
    go_phase(start_ph);
    spi_req = 1'b1;
    spi_we  = we;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (o1[5] === 1'b1) seen = 1'b1;
    end
    chk($sformatf("spi_latency_from_ph%0d", start_ph), seen ? 32'(n) : 32'hffff_ffff, 32'(exp_lat));
    tick();
    spi_req = 1'b0;
  endtask

  initial begin
    int last_rise;
    int rises;
    logic prev_clk;
    bit drop_next;
    int n;
    bit seen;

    // frame 1: SPI read requested from phase 0, CPU write
    tbl[0]  = mk(1,0,0, 3'b100, 3'b100, 2'b00, 2'b01);
    tbl[1]  = mk(1,0,0, 3'b100, 3'b000, 2'b00, 2'b01);
    tbl[2]  = mk(1,0,0, 3'b100, 3'b100, 2'b00, 2'b01);
    tbl[3]  = mk(1,0,0, 3'b010, 3'b000, 2'b00, 2'b11);
    tbl[4]  = mk(1,0,0, 3'b010, 3'b000, 2'b00, 2'b01);
    tbl[5]  = mk(1,0,0, 3'b010, 3'b010, 2'b00, 2'b01);
    tbl[6]  = mk(1,0,0, 3'b010, 3'b001, 2'b01, 2'b11);
    tbl[7]  = mk(1,0,0, 3'b001, 3'b000, 2'b11, 2'b11);
    tbl[8]  = mk(0,0,0, 3'b001, 3'b000, 2'b11, 2'b11);
    tbl[9]  = mk(0,0,0, 3'b001, 3'b000, 2'b11, 2'b11);
    tbl[10] = mk(0,0,0, 3'b001, 3'b000, 2'b11, 2'b10);
    tbl[11] = mk(0,0,0, 3'b001, 3'b000, 2'b11, 2'b10);
    tbl[12] = mk(0,0,0, 3'b001, 3'b000, 2'b11, 2'b10);
    tbl[13] = mk(0,0,0, 3'b001, 3'b000, 2'b11, 2'b10);
    tbl[14] = mk(0,0,0, 3'b001, 3'b000, 2'b11, 2'b11);
    tbl[15] = mk(0,0,0, 3'b100, 3'b000, 2'b00, 2'b01);
    // frame 2: no SPI request, CPU read
    tbl[16] = mk(0,0,1, 3'b100, 3'b100, 2'b00, 2'b01);
    tbl[17] = mk(0,0,1, 3'b100, 3'b000, 2'b00, 2'b01);
    tbl[18] = mk(0,0,1, 3'b100, 3'b100, 2'b00, 2'b01);
    tbl[19] = mk(0,0,1, 3'b000, 3'b000, 2'b00, 2'b11);
    tbl[20] = mk(0,0,1, 3'b000, 3'b000, 2'b00, 2'b11);
    tbl[21] = mk(0,0,1, 3'b000, 3'b000, 2'b00, 2'b11);
    tbl[22] = mk(0,0,1, 3'b000, 3'b000, 2'b01, 2'b11);
    tbl[23] = mk(0,0,1, 3'b001, 3'b000, 2'b11, 2'b11);
    for (int i = 24; i < 31; i++) tbl[i] = mk(0,0,1, 3'b001, 3'b000, 2'b11, 2'b01);
    tbl[31] = mk(0,0,1, 3'b100, 3'b000, 2'b00, 2'b01);

    // reset held three cycles
    for (int i = 0; i < 3; i++) tick();
    chk("reset_state", 32'(o1), 32'(11'b000_000_000_11));
    reset_i = 1'b0;

    // directed table straight out of reset
    for (int i = 0; i < 32; i++) begin
      spi_req = tbl[i].req;
      spi_we  = tbl[i].we;
      cpu_rw  = tbl[i].rw;
      tick();
      chk($sformatf("tbl%0d", i), 32'({o1[10:3], o1[1:0]}),
          32'({tbl[i].gnt, tbl[i].pls, tbl[i].cb, tbl[i].ram}));
    end

    // free-run: PHI2 period must be 16 cycles
    spi_req = 1'b0;
    cpu_rw = 1'b1;
    last_rise = -1;
    rises = 0;
    for (int c = 0; c < 64; c++) begin
      prev_clk = o1[4];
      tick();
      if (prev_clk === 1'b0 && o1[4] === 1'b1) begin
        if (last_rise >= 0) chk("phi2_period", 32'(c - last_rise), 32'd16);
        last_rise = c;
        rises++;
      end
    end
    chk("phi2_rises_in_64", 32'(rises), 32'd4);

    // SPI request timing: early in frame vs. after the sample edge
    spi_latency(3, 1'b0, 4);
    spi_latency(5, 1'b1, 18);

    // RDY only follows its input on the phase-0 edge
    cpu_ready = 1'b0;
    go_phase(1);
    go_phase(10);
    cpu_ready = 1'b1;
    go_phase(15);
    chk("rdy_hold_phi2_high", 32'(o1[2]), 32'd0);
    tick();
    chk("rdy_load_phase0", 32'(o1[2]), 32'd1);
    go_phase(3);
    cpu_ready = 1'b0;
    go_phase(12);
    cpu_ready = 1'b1;
    go_phase(0);
    chk("rdy_glitch_ignored", 32'(o1[2]), 32'd1);

    // random traffic under the request/ack handshake
    drop_next = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (drop_next) begin
        spi_req = 1'b0;
        drop_next = 1'b0;
      end else if (!spi_req && $urandom_range(0, 7) == 0) begin
        spi_req = 1'b1;
        spi_we  = 1'($urandom_range(0, 1));
      end
      cpu_rw    = 1'($urandom_range(0, 1));
      cpu_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (o1[5] === 1'b1) drop_next = 1'b1;
    end

    // reset asserted in phase 5 of an SPI write, then retry
    spi_req = 1'b0;
    go_phase(1);
    spi_req = 1'b1;
    spi_we  = 1'b1;
    go_phase(5);
    chk("rst_pre_we_low", 32'(o1[0]), 32'd0);
    reset_i = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("rst_async_clear", 32'({o1[10:8], o1[5], o1[1:0]}), 32'(6'b000_0_11));
    tick();
    tick();
    reset_i = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (o1[5] === 1'b1) seen = 1'b1;
    end
    chk("retry_after_reset", seen ? 32'(n) : 32'hffff_ffff, 32'd7);
    tick();
    spi_req = 1'b0;
    for (int i = 0; i < 16; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_scheduler.md
# bus_scheduler

Time-division scheduler for the shared system bus and RAM on the 16 MHz fabric clock. Divides each 1 µs CPU cycle into 16 phases and grants the bus in fixed slots to the video fetcher, the SPI/MCU bridge and the 6502. Generates the CPU clock, bus-enable and RDY outputs, and the RAM OE/WE strobes that the top level drives to the pins. Sits inside `main`, between the SPI register bridge, the video timing block and the bus pin drivers.

## Interface
Parameters:
- VIDEO_EN, 1: 1 = phases 0–3 are video slots; 0 = phases 0–3 idle (no grant, no strobes).

Ports:
- clk16_i  in  1  16 MHz system clock
- reset_i  in  1  asynchronous, active-high reset
- spi_req_i  in  1  MCU bridge requests one bus transaction; held until spi_ack_o
- spi_we_i  in  1  1 = SPI write, 0 = SPI read; stable while spi_req_i high
- spi_ack_o  out  1  one-cycle pulse: SPI transaction complete
- cpu_rw_ni  in  1  6502 R/W (1 = read), sampled during CPU slot
- cpu_ready_i  in  1  requested run/halt from MCU control register
- grant_video_o  out  1  video owns bus/RAM
- grant_spi_o  out  1  SPI bridge owns bus/RAM
- grant_cpu_o  out  1  CPU owns bus/RAM
- video_load_o  out  1  pulse: video latches RAM data
- spi_load_o  out  1  pulse: SPI bridge latches read data
- cpu_clk_o  out  1  1 MHz PHI2
- cpu_be_o  out  1  6502 bus enable
- cpu_ready_o  out  1  6502 RDY
- ram_oe_no  out  1  RAM output enable, active low
- ram_we_no  out  1  RAM write enable, active low

## Operation
- 4-bit phase counter, 0..15, increments every clk16_i, wraps 15→0.
- Slot map (grants registered, one-hot or all zero):
  - phases 0–1: video slot 0; phases 2–3: video slot 1 (VIDEO_EN=1).
  - phases 4–7: SPI slot, only if transaction accepted; else idle.
  - phases 8–15: CPU slot, always granted.
- cpu_clk_o = 1 in phases 8–15, 0 in phases 0–7.
- cpu_be_o = 1 in phases 7–15 (one phase of address setup before PHI2 rises).
- Video: ram_oe_no low phases 0–1 and 2–3; video_load_o high in phases 1 and 3.
- SPI accept: spi_req_i sampled on the edge entering phase 4; if high, transaction runs phases 4–7 with spi_we_i captured at that edge.
  - read: ram_oe_no low phases 5–6; spi_load_o high in phase 6.
  - write: ram_we_no low phases 5–6; ram_oe_no stays high.
  - spi_ack_o high in phase 7 only.
- CPU: cpu_rw_ni sampled entering phase 9; read → ram_oe_no low 9–15; write → ram_we_no low 11–14.
- ram_oe_no and ram_we_no never low in the same cycle; both high in every phase not listed above.
- cpu_ready_o loads cpu_ready_i only on the edge entering phase 0 (PHI2 low); never changes while PHI2 high.

## Timing
- Reset values: phase 0, all grants 0, cpu_clk_o 0, cpu_be_o 0, cpu_ready_o 0, ram_oe_no 1, ram_we_no 1, all pulses 0.
- On reset release, first clock enters phase 1; normal slot map from there.
- All outputs registered; no combinational input→output paths.
- SPI latency: request seen before the phase-4 edge → ack 4 cycles later; request arriving at phase 4 or later → waits for the next frame, worst case 19 cycles.
- Requester drops spi_req_i on the cycle after ack; a request still high at the next phase-4 edge is a new transaction.
- Reset mid-transaction: asynchronous return to reset values, no ack issued; requester retries.
- cpu_ready_i toggling mid-frame: only value at the phase-0 edge takes effect.

## Structure
- Package bus_sched_pkg: phase constants (PH_VID0, PH_VID1, PH_SPI, PH_CPU, PH_BE), strobe phase ranges, typedef enum slot_t {SLOT_IDLE, SLOT_VIDEO, SLOT_SPI, SLOT_CPU}.
- One sub-module: phase_counter (4-bit wrap counter with async reset); slot decode and strobes in bus_scheduler.

## Test plan
- Reset held 3 cycles, then free-run 64 cycles → cpu_clk_o period 16, high phases 8–15; cpu_be_o high 7–15; grants one-hot per slot map.
- spi_req_i=1, spi_we_i=0 raised in phase 2 → grant_spi_o phases 4–7, ram_oe_no low 5–6, spi_load_o in 6, spi_ack_o in 7.
- spi_req_i raised in phase 5, spi_we_i=1 → nothing this frame; next frame ram_we_no low 5–6, ack at phase 7 (latency 18).
- cpu_rw_ni=0 during CPU slot → ram_we_no low phases 11–14 only, ram_oe_no high; cpu_rw_ni=1 → ram_oe_no low 9–15.
- cpu_ready_i toggled at phase 10 → cpu_ready_o changes at next phase 0, not before.
- reset_i asserted at phase 5 of SPI write → ram_we_no high and grants 0 same cycle, no spi_ack_o; VIDEO_EN=0 run → no grants or strobes in phases 0–3.
